// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the decode hazard unit.
// No logic of its own; zero latency.
// No flow control here; consumers apply stall/forward decisions.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    HZ_ALU  = 2'd0,
    HZ_LOAD = 2'd1,
    HZ_LONG = 2'd2
  } hz_kind_e;

  localparam int FW_NONE = 0;

  function automatic int fw_width(input int fw_stages);
    return (fw_stages < 1) ? 1 : $clog2(fw_stages + 1);
  endfunction

  // First post-E stage at which a producer's result can be forwarded.
  function automatic int ready_stage(input logic is_load, input int load_lat);
    return is_load ? 1 + load_lat : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the datapath and the hazard unit.
// Purely wiring; outputs are combinational from the slave side.
// Master drives decode/long-unit status, slave returns stall and forward selects.
interface hazard_scoreboard_if #(
  parameter int NREGS     = 32,
  parameter int FW_STAGES = 2
);
  localparam int RW   = $clog2(NREGS);
  localparam int FW_W = hazard_scoreboard_pkg::fw_width(FW_STAGES);

  logic                               d_valid;
  logic [RW-1:0]                      d_rs1;
  logic [RW-1:0]                      d_rs2;
  logic                               d_use1;
  logic                               d_use2;
  logic [RW-1:0]                      d_rd;
  logic                               d_we;
  hazard_scoreboard_pkg::hz_kind_e    d_kind;
  logic                               flush;
  logic                               long_busy;
  logic                               long_wb_valid;
  logic [RW-1:0]                      long_wb_rd;
  logic                               stall;
  logic [FW_W-1:0]                    fw_a;
  logic [FW_W-1:0]                    fw_b;

  modport master (
    output d_valid, d_rs1, d_rs2, d_use1, d_use2, d_rd, d_we, d_kind,
    output flush, long_busy, long_wb_valid, long_wb_rd,
    input  stall, fw_a, fw_b
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use1, d_use2, d_rd, d_we, d_kind,
    input  flush, long_busy, long_wb_valid, long_wb_rd,
    output stall, fw_a, fw_b
  );
endinterface

// File: rtl/hazard_scoreboard_fw_sel.sv
// Youngest-producer match for one source register over tracked stages 1..FW_STAGES.
// Combinational, zero latency.
// No backpressure; pos is the matching stage (0 = none), rdy says it can forward.
module hazard_fw_sel
  import hazard_scoreboard_pkg::*;
#(
  parameter int FW_STAGES = 2,
  parameter int LOAD_LAT  = 1,
  parameter int RW        = 5,
  parameter int FW_W      = fw_width(FW_STAGES)
) (
  input  logic [RW-1:0]                 src,
  input  logic                          src_use,
  input  logic [FW_STAGES-1:0]          cand_wr,
  input  logic [FW_STAGES-1:0]          cand_load,
  input  logic [FW_STAGES-1:0][RW-1:0]  cand_rd,
  output logic [FW_W-1:0]               pos,
  output logic                          rdy
);
  logic found;

  // Candidate i sits at stage i+1; the first hit is the youngest producer.
  always_comb begin
    pos   = '0;
    rdy   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < FW_STAGES; i++) begin
      if (!found && src_use && (src != '0) && cand_wr[i] && (cand_rd[i] == src)) begin
        found = 1'b1;
        pos   = FW_W'(i + 1);
        rdy   = ((i + 1) >= ready_stage(cand_load[i], LOAD_LAT));
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: tracks in-flight rd across post-decode stages, picks E forwarding, stalls D.
// stall/fw are combinational from D inputs and registered state; D-to-E is 1 cycle.
// stall holds D and bubbles E; flush kills D. HAZARD_LONG_OP_EN adds the mul/div pend scoreboard.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int FW_STAGES = 2,
  parameter int LOAD_LAT  = 1,
  parameter int NREGS     = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave hz
);
  localparam int RW   = $clog2(NREGS);
  localparam int FW_W = fw_width(FW_STAGES);

  typedef struct packed {
    logic          vld;
    logic          we;
    hz_kind_e      kind;
    logic [RW-1:0] rd;
  } ent_t;

  typedef struct packed {
    logic          use1;
    logic          use2;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
  } src_t;

  ent_t [FW_STAGES:0]            pipe;
  src_t                          e_src;
  ent_t                          d_ent;
  src_t                          d_src;
  logic                          advance, stall, load_hz, long_hz;
  logic [FW_STAGES-1:0]          e_wr, e_ld, d_wr, d_ld;
  logic [FW_STAGES-1:0][RW-1:0]  e_rd, d_rdv;
  logic [FW_W-1:0]               pos_a, pos_b, pos_1, pos_2;
  logic                          rdy_a, rdy_b, rdy_1, rdy_2;

  always_comb begin
    advance   = hz.d_valid & ~stall & ~hz.flush;
    d_ent.vld = advance;
    d_ent.rd  = hz.d_rd;
`ifdef HAZARD_LONG_OP_EN
    // Long-op results never forward; the pend scoreboard owns them.
    d_ent.kind = hz.d_kind;
    d_ent.we   = hz.d_we & (hz.d_kind != HZ_LONG);
`else
    d_ent.kind = (hz.d_kind == HZ_LONG) ? HZ_ALU : hz.d_kind;
    d_ent.we   = hz.d_we;
`endif
    d_src.use1 = hz.d_use1;
    d_src.use2 = hz.d_use2;
    d_src.rs1  = hz.d_rs1;
    d_src.rs2  = hz.d_rs2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe  <= '0;
      e_src <= '0;
    end else begin
      pipe[0] <= d_ent;
      e_src   <= d_src;
      for (int k = 1; k <= FW_STAGES; k++) pipe[k] <= pipe[k-1];
    end
  end

  // E operands look at entries 1..N; the D check looks one stage earlier (entry s lands at s+1).
  always_comb begin
    for (int k = 0; k < FW_STAGES; k++) begin
      e_wr[k]  = pipe[k+1].vld & pipe[k+1].we;
      e_ld[k]  = (pipe[k+1].kind == HZ_LOAD);
      e_rd[k]  = pipe[k+1].rd;
      d_wr[k]  = pipe[k].vld & pipe[k].we;
      d_ld[k]  = (pipe[k].kind == HZ_LOAD);
      d_rdv[k] = pipe[k].rd;
    end
  end

  hazard_fw_sel #(.FW_STAGES(FW_STAGES), .LOAD_LAT(LOAD_LAT), .RW(RW), .FW_W(FW_W)) u_sel_a (
    .src(e_src.rs1), .src_use(pipe[0].vld & e_src.use1),
    .cand_wr(e_wr), .cand_load(e_ld), .cand_rd(e_rd), .pos(pos_a), .rdy(rdy_a));

  hazard_fw_sel #(.FW_STAGES(FW_STAGES), .LOAD_LAT(LOAD_LAT), .RW(RW), .FW_W(FW_W)) u_sel_b (
    .src(e_src.rs2), .src_use(pipe[0].vld & e_src.use2),
    .cand_wr(e_wr), .cand_load(e_ld), .cand_rd(e_rd), .pos(pos_b), .rdy(rdy_b));

  hazard_fw_sel #(.FW_STAGES(FW_STAGES), .LOAD_LAT(LOAD_LAT), .RW(RW), .FW_W(FW_W)) u_chk_1 (
    .src(hz.d_rs1), .src_use(hz.d_use1),
    .cand_wr(d_wr), .cand_load(d_ld), .cand_rd(d_rdv), .pos(pos_1), .rdy(rdy_1));

  hazard_fw_sel #(.FW_STAGES(FW_STAGES), .LOAD_LAT(LOAD_LAT), .RW(RW), .FW_W(FW_W)) u_chk_2 (
    .src(hz.d_rs2), .src_use(hz.d_use2),
    .cand_wr(d_wr), .cand_load(d_ld), .cand_rd(d_rdv), .pos(pos_2), .rdy(rdy_2));

  assign load_hz = ((pos_1 != '0) & ~rdy_1) | ((pos_2 != '0) & ~rdy_2);

`ifdef HAZARD_LONG_OP_EN
  logic [NREGS-1:0] pend, pend_set, pend_clr;

  assign pend_set = (advance && (hz.d_kind == HZ_LONG) && hz.d_we && (hz.d_rd != '0))
                    ? (NREGS'(1) << hz.d_rd) : '0;
  assign pend_clr = hz.long_wb_valid ? (NREGS'(1) << hz.long_wb_rd) : '0;

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~pend_clr) | pend_set;
  end

  assign long_hz = (hz.d_use1 & pend[hz.d_rs1])
                 | (hz.d_use2 & pend[hz.d_rs2])
                 | ((hz.d_kind == HZ_LONG) & (hz.long_busy | pend[hz.d_rd]))
                 | (hz.d_we & pend[hz.d_rd]);
`else
  assign long_hz = 1'b0;
`endif

  assign stall    = hz.d_valid & ~hz.flush & (load_hz | long_hz);
  assign hz.stall = stall;
  assign hz.fw_a  = rdy_a ? pos_a : FW_W'(FW_NONE);
  assign hz.fw_b  = rdy_b ? pos_b : FW_W'(FW_NONE);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: default config (dut_a) and LOAD_LAT=2/FW_STAGES=3 (dut_b).
// Expected stall/fw values are queued as each D slot is driven and compared mid-cycle.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  typedef struct {
    string tag;
    bit    on_b;
    bit    st;
    int    fa;
    int    fb;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard_if #(.NREGS(32), .FW_STAGES(2)) hza ();
  hazard_scoreboard_if #(.NREGS(32), .FW_STAGES(3)) hzb ();

  hazard_scoreboard #(.FW_STAGES(2), .LOAD_LAT(1), .NREGS(32)) dut_a (
    .clk(clk), .rst(rst), .hz(hza));

  hazard_scoreboard #(.FW_STAGES(3), .LOAD_LAT(2), .NREGS(32)) dut_b (
    .clk(clk), .rst(rst), .hz(hzb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic set_d(input bit v, input hz_kind_e k, input int rd, input bit we,
                       input int rs1, input bit u1, input int rs2, input bit u2);
    hza.d_valid = v;        hzb.d_valid = v;
    hza.d_kind  = k;        hzb.d_kind  = k;
    hza.d_rd    = 5'(rd);   hzb.d_rd    = 5'(rd);
    hza.d_we    = we;       hzb.d_we    = we;
    hza.d_rs1   = 5'(rs1);  hzb.d_rs1   = 5'(rs1);
    hza.d_use1  = u1;       hzb.d_use1  = u1;
    hza.d_rs2   = 5'(rs2);  hzb.d_rs2   = 5'(rs2);
    hza.d_use2  = u2;       hzb.d_use2  = u2;
  endtask

  task automatic idle();
    set_d(1'b0, HZ_ALU, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic set_ctl(input bit fl, input bit busy, input bit wbv, input int wbrd);
    hza.flush = fl;          hzb.flush = fl;
    hza.long_busy = busy;    hzb.long_busy = busy;
    hza.long_wb_valid = wbv; hzb.long_wb_valid = wbv;
    hza.long_wb_rd = 5'(wbrd); hzb.long_wb_rd = 5'(wbrd);
  endtask

  // Inputs are already applied; sample at negedge, then advance one clock.
  task automatic step(input string tag, input bit on_b, input bit st, input int fa, input int fb);
    exp_t e;
    exp_t x;
    e.tag = tag; e.on_b = on_b; e.st = st; e.fa = fa; e.fb = fb;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    if (x.on_b) begin
      chk({x.tag, ".stall"}, 32'(hzb.stall), 32'(x.st));
      chk({x.tag, ".fw_a"},  32'(hzb.fw_a),  32'(x.fa));
      chk({x.tag, ".fw_b"},  32'(hzb.fw_b),  32'(x.fb));
    end else begin
      chk({x.tag, ".stall"}, 32'(hza.stall), 32'(x.st));
      chk({x.tag, ".fw_a"},  32'(hza.fw_a),  32'(x.fa));
      chk({x.tag, ".fw_b"},  32'(hza.fw_b),  32'(x.fb));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_ctl(1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step("reset_a", 1'b0, 1'b0, 0, 0);
    step("reset_b", 1'b1, 1'b0, 0, 0);

    // ALU x5, then two consecutive readers of x5
    set_d(1'b1, HZ_ALU, 5, 1'b1, 1, 1'b1, 2, 1'b1);   step("alu_x5",  1'b0, 1'b0, 0, 0);
    set_d(1'b1, HZ_ALU, 9, 1'b1, 5, 1'b1, 0, 1'b0);   step("rd_x5_1", 1'b0, 1'b0, 0, 0);
    set_d(1'b1, HZ_ALU, 10, 1'b1, 5, 1'b1, 5, 1'b1);  step("rd_x5_2", 1'b0, 1'b0, 1, 0);
    idle();                                           step("rd_x5_3", 1'b0, 1'b0, 2, 2);
    step("drain1", 1'b0, 1'b0, 0, 0);

    // load-use on x6
    set_d(1'b1, HZ_LOAD, 6, 1'b1, 1, 1'b1, 0, 1'b0);  step("ld_x6",     1'b0, 1'b0, 0, 0);
    set_d(1'b1, HZ_ALU, 7, 1'b1, 6, 1'b1, 6, 1'b1);   step("lu_stall",  1'b0, 1'b1, 0, 0);
    step("lu_bubble", 1'b0, 1'b0, 0, 0);
    idle();                                           step("lu_fwd",    1'b0, 1'b0, 2, 2);
    step("drain2", 1'b0, 1'b0, 0, 0);

    // x0 never matches
    set_d(1'b1, HZ_LOAD, 0, 1'b1, 1, 1'b1, 0, 1'b0);  step("ld_x0",      1'b0, 1'b0, 0, 0);
    set_d(1'b1, HZ_ALU, 11, 1'b1, 0, 1'b1, 0, 1'b1);  step("x0_nostall", 1'b0, 1'b0, 0, 0);
    idle();                                           step("x0_fw",      1'b0, 1'b0, 0, 0);

    // load-use coincident with flush: no stall, and the killed slot becomes a bubble
    set_d(1'b1, HZ_LOAD, 6, 1'b1, 1, 1'b1, 0, 1'b0);  step("ld_x6_f", 1'b0, 1'b0, 0, 0);
    set_d(1'b1, HZ_ALU, 7, 1'b1, 6, 1'b1, 0, 1'b0);
    set_ctl(1'b1, 1'b0, 1'b0, 0);                     step("flush_ovr", 1'b0, 1'b0, 0, 0);
    set_ctl(1'b0, 1'b0, 1'b0, 0);
    set_d(1'b1, HZ_ALU, 12, 1'b1, 7, 1'b1, 6, 1'b1);  step("post_flush_d", 1'b0, 1'b0, 0, 0);
    idle();                                           step("post_flush_e", 1'b0, 1'b0, 0, 2);

    // reset mid-operation drops the load that was in D
    set_d(1'b1, HZ_LOAD, 6, 1'b1, 1, 1'b1, 0, 1'b0);
    rst = 1'b1;                                       step("rst_cyc", 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    set_d(1'b1, HZ_ALU, 7, 1'b1, 6, 1'b1, 0, 1'b0);   step("rst_flushed", 1'b0, 1'b0, 0, 0);
    idle();                                           step("rst_e", 1'b0, 1'b0, 0, 0);

`ifdef HAZARD_LONG_OP_EN
    set_d(1'b1, HZ_LONG, 8, 1'b1, 1, 1'b1, 0, 1'b0);  step("long_x8",     1'b0, 1'b0, 0, 0);
    set_d(1'b1, HZ_ALU, 12, 1'b1, 8, 1'b1, 0, 1'b0);  step("pend_stall0", 1'b0, 1'b1, 0, 0);
    step("pend_stall1", 1'b0, 1'b1, 0, 0);
    set_ctl(1'b0, 1'b0, 1'b1, 8);                     step("wb_cycle",    1'b0, 1'b1, 0, 0);
    set_ctl(1'b0, 1'b0, 1'b0, 0);                     step("pend_clr",    1'b0, 1'b0, 0, 0);
    idle();                                           step("long_fw",     1'b0, 1'b0, 0, 0);
    set_d(1'b1, HZ_LONG, 13, 1'b1, 0, 1'b0, 0, 1'b0);
    set_ctl(1'b0, 1'b1, 1'b0, 0);                     step("long_busy",   1'b0, 1'b1, 0, 0);
    set_ctl(1'b0, 1'b0, 1'b0, 0);
`else
    set_d(1'b1, HZ_LONG, 8, 1'b1, 1, 1'b1, 0, 1'b0);
    set_ctl(1'b0, 1'b1, 1'b0, 0);                     step("long_as_alu", 1'b0, 1'b0, 0, 0);
    set_ctl(1'b0, 1'b0, 1'b0, 0);
    set_d(1'b1, HZ_ALU, 12, 1'b1, 8, 1'b1, 0, 1'b0);  step("long_nopend", 1'b0, 1'b0, 0, 0);
    idle();                                           step("long_fw_alu", 1'b0, 1'b0, 1, 0);
`endif
    idle();
    step("drain3", 1'b0, 1'b0, 0, 0);

    // LOAD_LAT=2, FW_STAGES=3: load, independent op, consumer
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_d(1'b1, HZ_LOAD, 6, 1'b1, 1, 1'b1, 0, 1'b0);  step("b_ld",     1'b1, 1'b0, 0, 0);
    set_d(1'b1, HZ_ALU, 20, 1'b1, 1, 1'b1, 0, 1'b0);  step("b_indep",  1'b1, 1'b0, 0, 0);
    set_d(1'b1, HZ_ALU, 7, 1'b1, 6, 1'b1, 0, 1'b0);   step("b_stall",  1'b1, 1'b1, 0, 0);
    step("b_bubble", 1'b1, 1'b0, 0, 0);
    idle();                                           step("b_fwd",    1'b1, 1'b0, 3, 0);
    step("b_drain", 1'b1, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
